// File: rtl/uart_irq_ctrl_if.sv
// rtl/uart_irq_ctrl_if.sv - register-file/UART-core side signals of the interrupt sequencer
interface uart_irq_ctrl_if #(
  parameter int LOG_FIFO_DEPTH = 4
) ();
  logic [2:0]                irq_en_i;
  logic [1:0]                trg_level_i;
  logic                      bit_tick_i;
  logic                      lsr_err_i;
  logic                      rx_push_i;
  logic                      rx_pop_i;
  logic [LOG_FIFO_DEPTH:0]   rx_elem_i;
  logic [LOG_FIFO_DEPTH:0]   tx_elem_i;
  logic                      lsr_rd_i;
  logic                      iir_rd_i;
  logic                      thr_wr_i;
  logic [3:0]                iir_o;
  logic                      cti_o;
  logic                      irq_o;

  modport master (
    output irq_en_i, trg_level_i, bit_tick_i, lsr_err_i, rx_push_i, rx_pop_i,
           rx_elem_i, tx_elem_i, lsr_rd_i, iir_rd_i, thr_wr_i,
    input  iir_o, cti_o, irq_o
  );

  modport slave (
    input  irq_en_i, trg_level_i, bit_tick_i, lsr_err_i, rx_push_i, rx_pop_i,
           rx_elem_i, tx_elem_i, lsr_rd_i, iir_rd_i, thr_wr_i,
    output iir_o, cti_o, irq_o
  );
endinterface

// File: rtl/uart_irq_ctrl.sv
// rtl/uart_irq_ctrl.sv - 16550-style interrupt latching, prioritisation and character timeout
module uart_irq_ctrl #(
  parameter int FIFO_DEPTH     = 16,
  parameter int LOG_FIFO_DEPTH = $clog2(FIFO_DEPTH),
  parameter int BITS_PER_CHAR  = 10,
  parameter int CTI_CHARS      = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  uart_irq_ctrl_if.slave bus
);
  localparam int CTI_MAX = CTI_CHARS * BITS_PER_CHAR;
  localparam int TW      = $clog2(CTI_MAX + 1);
  localparam int EW      = LOG_FIFO_DEPTH + 1;

  localparam logic [3:0] IIR_RLS  = 4'b0110;
  localparam logic [3:0] IIR_RDA  = 4'b0100;
  localparam logic [3:0] IIR_CTI  = 4'b1100;
  localparam logic [3:0] IIR_THRE = 4'b0010;
  localparam logic [3:0] IIR_NONE = 4'b0001;

  logic [TW-1:0] timer_q, timer_d;
  logic          rls_q, rls_d;
  logic          cti_q, cti_d;
  logic          thre_q, thre_d;
  logic          thre_cond_q, thre_cond;
  logic [3:0]    iir_q, iir_d;
  logic          irq_q, irq_d;
  logic [EW-1:0] trig_cnt;
  logic          rx_empty;
  logic          rda;
  logic          timer_full;

  always_comb begin
    trig_cnt = EW'(1);
    case (bus.trg_level_i)
      2'b00:   trig_cnt = EW'(1);
      2'b01:   trig_cnt = EW'(4);
      2'b10:   trig_cnt = EW'(8);
      default: trig_cnt = EW'(14);
    endcase

    rx_empty   = (bus.rx_elem_i == '0);
    rda        = bus.irq_en_i[0] & (bus.rx_elem_i >= trig_cnt);
    timer_full = (timer_q == TW'(CTI_MAX));

    // Timer runs regardless of IER so re-enabling RDA/CTI does not restart it.
    timer_d = timer_q;
    if (bus.rx_push_i || bus.rx_pop_i || rx_empty) begin
      timer_d = '0;
    end else if (bus.bit_tick_i && !timer_full) begin
      timer_d = timer_q + 1'b1;
    end

    rls_d = rls_q;
    if (bus.lsr_err_i && bus.irq_en_i[2]) begin
      rls_d = 1'b1;
    end else if (bus.lsr_rd_i || !bus.irq_en_i[2]) begin
      rls_d = 1'b0;
    end

    cti_d = cti_q;
    if (bus.rx_pop_i || rx_empty || !bus.irq_en_i[0]) begin
      cti_d = 1'b0;
    end else if (timer_full) begin
      cti_d = 1'b1;
    end

    // Edge detect on "TX empty and enabled"; the IIR-read clear looks at the
    // code currently presented, so a fresh edge in the same cycle still wins
    // only if it was not the one being acknowledged.
    thre_cond = (bus.tx_elem_i == '0) & bus.irq_en_i[1];
    thre_d    = thre_q;
    if (bus.thr_wr_i || (bus.iir_rd_i && iir_q == IIR_THRE) || !bus.irq_en_i[1]) begin
      thre_d = 1'b0;
    end else if (thre_cond && !thre_cond_q) begin
      thre_d = 1'b1;
    end

    if (rls_q)       iir_d = IIR_RLS;
    else if (rda)    iir_d = IIR_RDA;
    else if (cti_q)  iir_d = IIR_CTI;
    else if (thre_q) iir_d = IIR_THRE;
    else             iir_d = IIR_NONE;

    irq_d = ~iir_d[0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer_q     <= '0;
      rls_q       <= 1'b0;
      cti_q       <= 1'b0;
      thre_q      <= 1'b0;
      thre_cond_q <= 1'b0;
      iir_q       <= IIR_NONE;
      irq_q       <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      rls_q       <= rls_d;
      cti_q       <= cti_d;
      thre_q      <= thre_d;
      thre_cond_q <= thre_cond;
      iir_q       <= iir_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.iir_o = iir_q;
  assign bus.cti_o = cti_q;
  assign bus.irq_o = irq_q;
endmodule

// File: tb/tb_uart_irq_ctrl.sv
// tb/tb_uart_irq_ctrl.sv - directed and randomized checks of uart_irq_ctrl against a reference model
module tb_uart_irq_ctrl;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  uart_irq_ctrl_if #(.LOG_FIFO_DEPTH(4)) u_if ();

  uart_irq_ctrl #(.FIFO_DEPTH(16)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (u_if.slave)
  );

  always #5 clk_i = ~clk_i;

  int       rx_cnt, tx_cnt;
  int       m_timer;
  bit       m_rls, m_cti, m_thre, m_prev, m_irq;
  int       m_iir;

  task automatic check_eq(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int trig_of(input logic [1:0] t);
    case (t)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 14;
    endcase
  endfunction

  task automatic model_reset();
    m_timer = 0; m_rls = 0; m_cti = 0; m_thre = 0; m_prev = 0;
    m_iir = 1; m_irq = 0;
  endtask

  task automatic model_step();
    bit en0, en1, en2, empty, rda, cond;
    int n_iir;
    en0   = u_if.irq_en_i[0];
    en1   = u_if.irq_en_i[1];
    en2   = u_if.irq_en_i[2];
    empty = (rx_cnt == 0);
    rda   = en0 && (rx_cnt >= trig_of(u_if.trg_level_i));
    cond  = (tx_cnt == 0) && en1;

    if (m_rls)       n_iir = 6;
    else if (rda)    n_iir = 4;
    else if (m_cti)  n_iir = 12;
    else if (m_thre) n_iir = 2;
    else             n_iir = 1;

    if (u_if.lsr_err_i && en2)          m_rls = 1;
    else if (u_if.lsr_rd_i || !en2)     m_rls = 0;

    if (u_if.rx_pop_i || empty || !en0) m_cti = 0;
    else if (m_timer == 40)             m_cti = 1;

    if (u_if.thr_wr_i || (u_if.iir_rd_i && m_iir == 2) || !en1) m_thre = 0;
    else if (cond && !m_prev)           m_thre = 1;
    m_prev = cond;

    if (u_if.rx_push_i || u_if.rx_pop_i || empty) m_timer = 0;
    else if (u_if.bit_tick_i && m_timer < 40)     m_timer = m_timer + 1;

    m_iir = n_iir;
    m_irq = (n_iir != 1);
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_step();
    #1;
    check_eq("iir", u_if.iir_o, 4'(m_iir));
    check_eq("irq", {3'b0, u_if.irq_o}, {3'b0, m_irq});
    check_eq("cti", {3'b0, u_if.cti_o}, {3'b0, m_cti});
    if (u_if.rx_push_i) rx_cnt++;
    if (u_if.rx_pop_i)  rx_cnt--;
    u_if.rx_elem_i  = 5'(rx_cnt);
    u_if.tx_elem_i  = 5'(tx_cnt);
    u_if.bit_tick_i = 0; u_if.lsr_err_i = 0; u_if.rx_push_i = 0; u_if.rx_pop_i = 0;
    u_if.lsr_rd_i   = 0; u_if.iir_rd_i  = 0; u_if.thr_wr_i  = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_tx(input int v);
    tx_cnt = v;
    u_if.tx_elem_i = 5'(v);
  endtask

  task automatic drain_rx();
    while (rx_cnt > 0) begin u_if.rx_pop_i = 1; cycle(); end
    idle(2);
  endtask

  initial begin
    rx_cnt = 0; tx_cnt = 5;
    u_if.irq_en_i = 3'b000; u_if.trg_level_i = 2'b00;
    u_if.bit_tick_i = 0; u_if.lsr_err_i = 0; u_if.rx_push_i = 0; u_if.rx_pop_i = 0;
    u_if.rx_elem_i = 0; u_if.tx_elem_i = 5'd5;
    u_if.lsr_rd_i = 0; u_if.iir_rd_i = 0; u_if.thr_wr_i = 0;
    model_reset();
    #12;
    check_eq("rst_iir", u_if.iir_o, 4'b0001);
    check_eq("rst_irq", {3'b0, u_if.irq_o}, 4'b0000);
    check_eq("rst_cti", {3'b0, u_if.cti_o}, 4'b0000);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    idle(2);

    // RX trigger level reached, then dropped below
    u_if.irq_en_i = 3'b001; u_if.trg_level_i = 2'b10;
    for (int i = 0; i < 8; i++) begin u_if.rx_push_i = 1; cycle(); end
    idle(2);
    check_eq("t1_rda_iir", u_if.iir_o, 4'b0100);
    check_eq("t1_rda_irq", {3'b0, u_if.irq_o}, 4'b0001);
    u_if.rx_pop_i = 1; cycle(); idle(1);
    check_eq("t1_pop_iir", u_if.iir_o, 4'b0001);
    drain_rx();

    // Character timeout after 40 idle bit times
    u_if.trg_level_i = 2'b11;
    u_if.rx_push_i = 1; cycle();
    for (int i = 0; i < 40; i++) begin u_if.bit_tick_i = 1; cycle(); end
    idle(2);
    check_eq("t2_cti", {3'b0, u_if.cti_o}, 4'b0001);
    check_eq("t2_iir", u_if.iir_o, 4'b1100);
    u_if.rx_pop_i = 1; cycle(); idle(1);
    check_eq("t2_pop_cti", {3'b0, u_if.cti_o}, 4'b0000);
    check_eq("t2_pop_iir", u_if.iir_o, 4'b0001);

    // Line status preempts RDA without dropping irq
    u_if.irq_en_i = 3'b111; u_if.trg_level_i = 2'b00;
    u_if.rx_push_i = 1; cycle(); idle(2);
    check_eq("t3_rda", u_if.iir_o, 4'b0100);
    u_if.lsr_err_i = 1; cycle();
    check_eq("t3_irq_a", {3'b0, u_if.irq_o}, 4'b0001);
    idle(1);
    check_eq("t3_rls", u_if.iir_o, 4'b0110);
    u_if.lsr_rd_i = 1; cycle();
    check_eq("t3_irq_b", {3'b0, u_if.irq_o}, 4'b0001);
    idle(1);
    check_eq("t3_back", u_if.iir_o, 4'b0100);
    check_eq("t3_irq_c", {3'b0, u_if.irq_o}, 4'b0001);
    drain_rx();

    // THR empty: drain edge, IIR-read ack, re-enable edge, THR write ack
    u_if.irq_en_i = 3'b010; set_tx(3);
    idle(1);
    for (int v = 2; v >= 0; v--) begin set_tx(v); cycle(); end
    idle(2);
    check_eq("t4_thre", u_if.iir_o, 4'b0010);
    u_if.iir_rd_i = 1; cycle(); idle(1);
    check_eq("t4_iir_rd", u_if.iir_o, 4'b0001);
    u_if.irq_en_i = 3'b000; cycle();
    u_if.irq_en_i = 3'b010; cycle(); idle(1);
    check_eq("t4_reen", u_if.iir_o, 4'b0010);
    u_if.thr_wr_i = 1; cycle(); idle(1);
    check_eq("t4_thr_wr", u_if.iir_o, 4'b0001);

    // Error and LSR read in the same cycle: set wins
    u_if.irq_en_i = 3'b100; set_tx(5);
    idle(1);
    u_if.lsr_err_i = 1; u_if.lsr_rd_i = 1; cycle(); idle(1);
    check_eq("t5_setwins", u_if.iir_o, 4'b0110);
    u_if.lsr_rd_i = 1; cycle(); idle(1);
    check_eq("t5_clr", u_if.iir_o, 4'b0001);

    // Async reset mid-count restarts the timeout timer
    u_if.irq_en_i = 3'b001; u_if.trg_level_i = 2'b11;
    u_if.rx_push_i = 1; cycle();
    for (int i = 0; i < 25; i++) begin u_if.bit_tick_i = 1; cycle(); end
    #2 rst_n_i = 1'b0;
    #1;
    model_reset();
    check_eq("t6_rst_iir", u_if.iir_o, 4'b0001);
    check_eq("t6_rst_irq", {3'b0, u_if.irq_o}, 4'b0000);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 39; i++) begin u_if.bit_tick_i = 1; cycle(); end
    idle(2);
    check_eq("t6_39", {3'b0, u_if.cti_o}, 4'b0000);
    u_if.bit_tick_i = 1; cycle(); idle(2);
    check_eq("t6_40", {3'b0, u_if.cti_o}, 4'b0001);
    drain_rx();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) u_if.irq_en_i = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) u_if.trg_level_i = 2'($urandom_range(0, 3));
      u_if.bit_tick_i = ($urandom_range(0, 1) == 1);
      u_if.lsr_err_i  = ($urandom_range(0, 79) == 0);
      u_if.lsr_rd_i   = ($urandom_range(0, 39) == 0);
      u_if.iir_rd_i   = ($urandom_range(0, 19) == 0);
      if (rx_cnt < 16 && $urandom_range(0, 59) == 0) u_if.rx_push_i = 1;
      else if (rx_cnt > 0 && $urandom_range(0, 79) == 0) u_if.rx_pop_i = 1;
      if ($urandom_range(0, 49) == 0) begin
        u_if.thr_wr_i = 1;
        if (tx_cnt < 16) set_tx(tx_cnt + 1);
      end else if (tx_cnt > 0 && $urandom_range(0, 9) == 0) begin
        set_tx(tx_cnt - 1);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
